// File: rtl/keypad_scan_decoder.sv
// Matrix keypad scanner: strobes rows, samples active-low columns, debounces
// whole frames and hands single-key presses to a reader via valid/read.
module keypad_scan_decoder #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 16,
    parameter int DEBOUNCE = 3,
    localparam int CODE_W  = $clog2(ROWS*COLS)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ROWS-1:0]   row_n,
    input  logic [COLS-1:0]   col_n,
    input  logic              key_rd,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code,
    output logic              key_ovf,
    output logic              key_down
);
    localparam int N     = ROWS*COLS;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int STB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic [DIV_W-1:0]  div_q, div_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [N-1:0]      frame_q, frame_d;
    logic [N-1:0]      prev_q, prev_d;
    logic [STB_W-1:0]  stab_q, stab_d;
    logic [N-1:0]      deb_q, deb_d;
    logic              down_q, down_d;
    logic              valid_q, valid_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              ovf_q, ovf_d;

    logic              tick;
    logic              frame_done;
    logic              ev;
    logic [N-1:0]      new_frame;
    logic [CODE_W-1:0] new_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            row_q   <= '0;
            frame_q <= '0;
            prev_q  <= '0;
            stab_q  <= '0;
            deb_q   <= '0;
            down_q  <= 1'b0;
            valid_q <= 1'b0;
            code_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            div_q   <= div_d;
            row_q   <= row_d;
            frame_q <= frame_d;
            prev_q  <= prev_d;
            stab_q  <= stab_d;
            deb_q   <= deb_d;
            down_q  <= down_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        div_d      = div_q + DIV_W'(1);
        row_d      = row_q;
        frame_d    = frame_q;
        prev_d     = prev_q;
        stab_d     = stab_q;
        deb_d      = deb_q;
        valid_d    = valid_q;
        code_d     = code_q;
        ovf_d      = ovf_q;
        ev         = 1'b0;
        new_code   = '0;
        tick       = (div_q == DIV_W'(SCAN_DIV-1));
        frame_done = tick && (row_q == ROW_W'(ROWS-1));
        new_frame  = frame_q;
        new_frame[int'(row_q)*COLS +: COLS] = ~col_n;

        if (tick) begin
            div_d   = '0;
            frame_d = new_frame;
            row_d   = (row_q == ROW_W'(ROWS-1)) ? '0 : row_q + ROW_W'(1);
        end

        if (frame_done) begin
            if (new_frame == prev_q) begin
                if (stab_q != STB_W'(DEBOUNCE-1))
                    stab_d = stab_q + STB_W'(1);
            end else begin
                stab_d = '0;
                prev_d = new_frame;
            end
            if (stab_d == STB_W'(DEBOUNCE-1)) begin
                deb_d = prev_d;
                // only an idle-to-single-key transition counts as a press
                ev = (deb_q == '0) && (prev_d != '0) &&
                     ((prev_d & (prev_d - N'(1))) == '0);
            end
        end

        for (int i = 0; i < N; i++)
            if (deb_d[i]) new_code = CODE_W'(i);

        down_d = |deb_d;

        if (key_rd && valid_q && ev) begin
            code_d = new_code;
            ovf_d  = 1'b0;
        end else if (key_rd && valid_q) begin
            valid_d = 1'b0;
            ovf_d   = 1'b0;
        end else if (ev && !valid_q) begin
            valid_d = 1'b1;
            code_d  = new_code;
        end else if (ev) begin
            ovf_d = 1'b1;
        end
    end

    assign row_n     = ~(ROWS'(1) << row_q);
    assign key_valid = valid_q;
    assign key_code  = code_q;
    assign key_ovf   = ovf_q;
    assign key_down  = down_q;
endmodule

// File: tb/tb_keypad_scan_decoder.sv
// Bench for keypad_scan_decoder: keypad matrix model, vector table, event
// scoreboard and hand-written bounce / overflow / reset sequences.
module tb_keypad_scan_decoder;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic       key_rd;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ovf;
    logic       key_down;
    logic [15:0] keys;

    int n_vec = 0;
    int n_err = 0;
    logic [3:0] exp_q[$];
    logic       prev_valid = 1'b0;

    typedef struct {
        logic [15:0] keys;
        logic        ev;
        logic [3:0]  code;
        logic        down;
    } vec_t;
    vec_t tbl[6];

    localparam int FRAME = 16;
    localparam int SETTLE = 6*FRAME;

    keypad_scan_decoder #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3)
    ) dut (
        .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n),
        .key_rd(key_rd), .key_valid(key_valid), .key_code(key_code),
        .key_ovf(key_ovf), .key_down(key_down)
    );

    always #5 clk = ~clk;

    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!row_n[r]) col_n = col_n & ~keys[r*4 +: 4];
    end

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard: each key_valid rise must match the next expected code
    always @(negedge clk) begin
        if (key_valid && !prev_valid) begin
            if (exp_q.size() == 0)
                check("spurious_evt", 16'(key_valid), 16'd0);
            else
                check("evt_code", 16'(key_code), 16'(exp_q.pop_front()));
        end
        prev_valid = key_valid;
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic read_key();
        key_rd = 1'b1;
        clks(1);
        key_rd = 1'b0;
        check("rd_valid", 16'(key_valid), 16'd0);
        check("rd_ovf", 16'(key_ovf), 16'd0);
    endtask

    initial begin
        tbl[0] = '{16'h0200, 1'b1, 4'd9,  1'b1};
        tbl[1] = '{16'h0008, 1'b1, 4'd3,  1'b1};
        tbl[2] = '{16'h0050, 1'b0, 4'd0,  1'b1};
        tbl[3] = '{16'h8000, 1'b1, 4'd15, 1'b1};
        tbl[4] = '{16'h0001, 1'b1, 4'd0,  1'b1};
        tbl[5] = '{16'h1100, 1'b0, 4'd0,  1'b1};

        keys = '0;
        key_rd = 1'b0;
        rst = 1'b1;
        clks(3);
        check("rst_row", 16'(row_n), 16'hE);
        check("rst_valid", 16'(key_valid), 16'd0);
        check("rst_code", 16'(key_code), 16'd0);
        check("rst_ovf", 16'(key_ovf), 16'd0);
        check("rst_down", 16'(key_down), 16'd0);
        rst = 1'b0;
        clks(4);
        check("row_4", 16'(row_n), 16'hD);
        clks(4);
        check("row_8", 16'(row_n), 16'hB);
        clks(4);
        check("row_12", 16'(row_n), 16'h7);
        clks(4);
        check("row_16", 16'(row_n), 16'hE);

        for (int i = 0; i < 6; i++) begin
            keys = tbl[i].keys;
            if (tbl[i].ev) exp_q.push_back(tbl[i].code);
            clks(SETTLE);
            check("tbl_down", 16'(key_down), 16'(tbl[i].down));
            check("tbl_valid", 16'(key_valid), 16'(tbl[i].ev));
            check("tbl_ovf", 16'(key_ovf), 16'd0);
            if (tbl[i].ev) check("tbl_code", 16'(key_code), 16'(tbl[i].code));
            read_key();
            keys = '0;
            clks(SETTLE);
            check("rel_down", 16'(key_down), 16'd0);
            check("rel_valid", 16'(key_valid), 16'd0);
        end

        // bounce for two frames, then hold
        exp_q.push_back(4'd9);
        for (int t = 0; t < 32; t += 10) begin
            keys = (keys == 16'h0) ? 16'h0200 : 16'h0;
            clks(10);
        end
        check("bounce_valid", 16'(key_valid), 16'd0);
        keys = 16'h0200;
        clks(SETTLE);
        check("bounce_evt", 16'(key_valid), 16'd1);
        check("bounce_code", 16'(key_code), 16'd9);
        check("bounce_ovf", 16'(key_ovf), 16'd0);
        read_key();
        keys = '0;
        clks(SETTLE);

        // lost press while a key is pending
        exp_q.push_back(4'd3);
        keys = 16'h0008;
        clks(SETTLE);
        check("ovf_first", 16'(key_code), 16'd3);
        keys = '0;
        clks(SETTLE);
        check("ovf_pre", 16'(key_ovf), 16'd0);
        keys = 16'h1000;
        clks(SETTLE);
        check("ovf_set", 16'(key_ovf), 16'd1);
        check("ovf_code", 16'(key_code), 16'd3);
        check("ovf_valid", 16'(key_valid), 16'd1);
        read_key();
        keys = '0;
        clks(SETTLE);

        // reset mid-frame with a key held
        exp_q.push_back(4'd9);
        keys = 16'h0200;
        clks(SETTLE + 7);
        check("pre_rst_valid", 16'(key_valid), 16'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", 16'(key_valid), 16'd0);
        check("mid_rst_down", 16'(key_down), 16'd0);
        check("mid_rst_code", 16'(key_code), 16'd0);
        check("mid_rst_row", 16'(row_n), 16'hE);
        exp_q.push_back(4'd9);
        clks(2);
        rst = 1'b0;
        clks(SETTLE);
        check("post_rst_valid", 16'(key_valid), 16'd1);
        check("post_rst_code", 16'(key_code), 16'd9);
        check("post_rst_down", 16'(key_down), 16'd1);
        read_key();
        keys = '0;
        clks(SETTLE);

        check("sb_empty", 16'(exp_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
